// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier.
// Build option: define BOOTH4_MULT_EARLY_TERM_EN to enable early termination.
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_e;

  // Number of radix-4 digits covering a WIDTH+2 bit extended multiplier.
  function automatic int unsigned calc_n(input int unsigned width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth4_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window -> digit and selected addend.
module booth4_recode
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       window_i,
  input  logic [WIDTH+1:0] a_i,
  output booth_digit_e     digit_c,
  output logic [WIDTH+2:0] addend_c
);

  logic [WIDTH+2:0] a_sx;

  // Decode the window and form 0, +-A or +-2A at accumulator width.
  always_comb begin
    a_sx     = {a_i[WIDTH+1], a_i};
    digit_c  = ZERO;
    addend_c = '0;
    unique case (window_i)
      3'b001, 3'b010: digit_c = P1;
      3'b011:         digit_c = P2;
      3'b100:         digit_c = M2;
      3'b101, 3'b110: digit_c = M1;
      default:        digit_c = ZERO;
    endcase
    unique case (digit_c)
      P1:      addend_c = a_sx;
      P2:      addend_c = a_sx << 1;
      M1:      addend_c = -a_sx;
      M2:      addend_c = -(a_sx << 1);
      default: addend_c = '0;
    endcase
  end

endmodule

// File: rtl/booth4_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned, valid/ready/yumi handshake.
// Build option: BOOTH4_MULT_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits can only produce zero digits.
module booth4_mult
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               signed_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [2*WIDTH-1:0] data_o
);

  localparam int unsigned N     = calc_n(WIDTH);
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned EXT_W = WIDTH + 2;
  localparam int unsigned ACC_W = WIDTH + 3;
  // Layout: {accumulator, multiplier/low product bits, Booth overlap bit}.
  localparam int unsigned REG_W = ACC_W + EXT_W + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_W-1:0]   prod_q, prod_d;
  logic [EXT_W-1:0]   a_q, a_d;

  logic               accept;
  logic               last_step;
  logic [EXT_W-1:0]   a_ext, b_ext;
  booth_digit_e       digit;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_sum;
  logic [REG_W-1:0]   stepped;

  assign ready_o   = (state_q == S_IDLE) || ((state_q == S_HOLD) && yumi_i);
  assign v_o       = (state_q == S_HOLD);
  assign data_o    = prod_q[2*WIDTH:1];
  assign accept    = v_i && ready_o;
  assign last_step = (cnt_q == CNT_W'(N - 1));
  assign a_ext     = {{2{signed_i & a_i[WIDTH-1]}}, a_i};
  assign b_ext     = {{2{signed_i & b_i[WIDTH-1]}}, b_i};

  booth4_recode #(.WIDTH(WIDTH)) u_recode (
    .window_i (prod_q[2:0]),
    .a_i      (a_q),
    .digit_c  (digit),
    .addend_c (addend)
  );

  // One Booth step: add the selected addend, then shift the whole register by 2.
  always_comb begin
    acc_sum = prod_q[REG_W-1 -: ACC_W];
    if (digit != ZERO) acc_sum = prod_q[REG_W-1 -: ACC_W] + addend;
    stepped = REG_W'($signed({acc_sum, prod_q[EXT_W:0]}) >>> 2);
  end

`ifdef BOOTH4_MULT_EARLY_TERM_EN
  int unsigned      step_j;
  logic [EXT_W:0]   rem_mask;
  logic [EXT_W:0]   rem_bits;
  logic             early_done;
  logic [REG_W-1:0] early_val;

  // Remaining windows are all zero digits when leftover bits plus overlap are uniform.
  always_comb begin
    step_j     = 32'(cnt_q) + 32'd1;
    rem_mask   = {(EXT_W + 1){1'b1}} >> (2 * step_j);
    rem_bits   = stepped[EXT_W:0];
    early_done = ((rem_bits & rem_mask) == '0) || ((rem_bits | ~rem_mask) == '1);
    early_val  = REG_W'($signed(stepped) >>> (2 * (N - step_j)));
  end
`endif

  // Next-state, counter and datapath register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    a_d     = a_q;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (accept) begin
          a_d     = a_ext;
          prod_d  = {ACC_W'(0), b_ext, 1'b0};
          cnt_d   = '0;
          state_d = S_COMPUTE;
        end else if ((state_q == S_HOLD) && yumi_i) begin
          state_d = S_IDLE;
        end
      end
      S_COMPUTE: begin
        cnt_d  = cnt_q + CNT_W'(1);
        prod_d = stepped;
        if (last_step) state_d = S_HOLD;
`ifdef BOOTH4_MULT_EARLY_TERM_EN
        if (early_done) begin
          prod_d  = early_val;
          state_d = S_HOLD;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears any in-flight product.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      a_q     <= a_d;
    end
  end

endmodule

// File: doc/booth4_mult.md
BOOTH4_MULT -- requirements
Module: booth4_mult

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand width; it must be even and at least 4.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n_i  input  1  reset, asynchronous and active-low.
REQ-004 v_i  input  1  operands valid.
REQ-005 ready_o  output  1  module can accept operands this cycle.
REQ-006 a_i  input  WIDTH  multiplicand.
REQ-007 b_i  input  WIDTH  multiplier.
REQ-008 signed_i  input  1  1 treats a_i and b_i as two's complement; 0 treats them as unsigned.
REQ-009 v_o  output  1  product valid.
REQ-010 yumi_i  input  1  consumer takes the product this cycle; asserted only while v_o is 1.
REQ-011 data_o  output  2*WIDTH  product.

Function
REQ-012 The FSM SHALL have the states S_IDLE, S_COMPUTE and S_HOLD.
REQ-013 Accept SHALL occur when v_i and ready_o are both 1; on accept, latch a_i, b_i and signed_i, and go to S_COMPUTE.
REQ-014 Operands SHALL be extended to WIDTH+2 bits: sign-extended when signed_i=1, zero-extended when signed_i=0.
REQ-015 Each S_COMPUTE cycle SHALL retire 2 multiplier bits using radix-4 Booth recoding (digits 0, +A, +2A, -A, -2A), followed by a 2-bit arithmetic right shift of the partial-product register.
REQ-016 Without early termination, S_COMPUTE SHALL last exactly N = WIDTH/2 + 1 cycles, then go to S_HOLD.
REQ-017 v_o SHALL be 1 exactly in S_HOLD; data_o SHALL be the low 2*WIDTH bits of the exact product and SHALL stay stable throughout S_HOLD.
REQ-018 ready_o SHALL be 1 in S_IDLE, and in S_HOLD only when yumi_i=1; it SHALL be 0 in S_COMPUTE.
REQ-019 S_HOLD with yumi_i=1 and v_i=0 SHALL go to S_IDLE; with yumi_i=1 and v_i=1 it SHALL accept new operands and go directly to S_COMPUTE (back-to-back, no bubble).
REQ-020 S_HOLD with yumi_i=0 SHALL stay in S_HOLD and ignore v_i.
REQ-021 v_i and operand changes during S_COMPUTE SHALL be ignored.
REQ-022 The cycle counter SHALL be ceil(log2(N+1)) bits wide, SHALL clear on accept, and SHALL never wrap.
REQ-023 All cases SHALL give exact results, including -2^(WIDTH-1) * -2^(WIDTH-1) signed and (2^WIDTH - 1)^2 unsigned.

Reset
REQ-024 Assertion of reset_n_i=0 SHALL immediately force S_IDLE, v_o=0, ready_o=1, data_o=0 and counter=0, including mid-compute and mid-hold.
REQ-025 No product from an interrupted operation SHALL ever appear after reset.
REQ-026 On the first rising edge after reset_n_i rises, the module SHALL be able to accept.

Configuration
REQ-027 Macro BOOTH4_MULT_EARLY_TERM_EN, when defined, SHALL enable early termination.
REQ-028 With the macro defined, after compute step j (1..N) the block SHALL check the unconsumed multiplier bits plus the Booth overlap bit.
REQ-029 If those bits are all 0s or all 1s, the block SHALL arithmetic-shift the register right by 2*(N-j) bits, go to S_HOLD, and deliver the same data_o as without the macro.
REQ-030 With the macro defined, S_COMPUTE SHALL last at least 1 cycle and at most N cycles.
REQ-031 Without the macro, latency SHALL be fixed at N compute cycles, and no comparator or barrel-shift logic SHALL be synthesised.

Structure
REQ-032 Package booth_pkg SHALL hold the state enum, the Booth digit enum (ZERO, P1, P2, M1, M2), and the function computing N from WIDTH.
REQ-033 The combinational sub-module booth4_recode SHALL map a 3-bit multiplier window to a Booth digit and produce the selected WIDTH+3-bit addend.
REQ-034 The top level SHALL contain only the FSM, the counter, the registers and the adder.

Verification (WIDTH=8, macro undefined unless stated)
REQ-035 Signed 3 * -5 (a=0x03, b=0xFB, signed_i=1) -> data_o=0xFFF1 after 5 compute cycles, v_o held until yumi_i.
REQ-036 Unsigned 0xFF * 0xFF (signed_i=0) -> data_o=0xFE01; signed 0x80 * 0x80 -> data_o=0x4000.
REQ-037 Back-to-back: in S_HOLD, yumi_i=1 with v_i=1 and new operands 7*6 signed -> new operands accepted the same cycle, next data_o=0x002A, and no idle cycle between operations.
REQ-038 reset_n_i pulsed low during the third compute cycle -> v_o=0 and ready_o=1 immediately; a following 2*2 gives 0x0004, with no stale result.
REQ-039 With the macro defined, signed 7 * 1 -> data_o=0x0007 with S_COMPUTE shorter than 5 cycles; a randomized signed/unsigned sweep matches the macro-undefined results bit-for-bit.
